// File: rtl/hazard_controller.sv
// Decode-stage sequencer: load-use bubble, branch flush, data-memory freeze with timeout.
// Outputs are combinational from state and inputs; the pipeline is held while rst_n is low.
module hazard_controller #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instruc,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT, ERROR} state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       uses_rt, load_use, mem_stall;
  logic       pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c, pipe_hold_c;
  logic       unused_bits;

  assign opcode      = id_instruc[31:26];
  assign rs          = id_instruc[25:21];
  assign rt          = id_instruc[20:16];
  assign unused_bits = ^id_instruc[15:0];

  assign uses_rt   = (opcode == 6'b000000) || (opcode == 6'b101011) ||
                     (opcode == 6'b000100) || (opcode == 6'b000101);
  assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  assign mem_stall = mem_req && !dmem_ready;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    pc_write_c      = 1'b1;
    if_id_write_c   = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    pipe_hold_c     = 1'b0;
    case (state_q)
      RUN, LU_BUBBLE: begin
        if (mem_stall) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          pipe_hold_c   = 1'b1;
          wait_cnt_d    = TO_W'(1);
          state_d       = (MEM_TIMEOUT <= 1) ? ERROR : MEM_WAIT;
        end else if (ex_branch_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          state_d        = RUN;
        end else if (load_use && (state_q == RUN)) begin
          // The bubble cycle masks load_use so one hazard never costs two bubbles.
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          state_d        = LU_BUBBLE;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          if (ex_branch_taken) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
          end else if (load_use) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
          end
          wait_cnt_d = '0;
          state_d    = RUN;
        end else begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          pipe_hold_c   = 1'b1;
          wait_cnt_d    = wait_cnt_q + TO_W'(1);
          if (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1)) state_d = ERROR;
        end
      end
      ERROR: begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        pipe_hold_c    = 1'b1;
        id_ex_bubble_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (!pc_write_c && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Reset forces the frozen/bubbled pattern straight away, independent of the clock.
  assign pc_write     = rst_n && pc_write_c;
  assign if_id_write  = rst_n && if_id_write_c;
  assign if_id_flush  = rst_n && if_id_flush_c;
  assign id_ex_bubble = !rst_n || id_ex_bubble_c;
  assign pipe_hold    = !rst_n || pipe_hold_c;
  assign mem_err      = rst_n && (state_q == ERROR);
  assign stall_count  = stall_cnt_q;

endmodule
